// File: rtl/sseg_display_arbiter.sv
//==============================================================================
// Module  : sseg_display_arbiter
// Brief   : Round-robin owner of a shared 4-digit seven-segment display with
//           minimum hold time; grants and frame data switch only between frames.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module sseg_display_arbiter #(
    parameter int N_REQ       = 2,
    parameter int SCAN_TICKS  = 100000,
    parameter int HOLD_FRAMES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [32*N_REQ-1:0]  frame,
    output logic [N_REQ-1:0]     grant,
    output logic [3:0]           an,
    output logic [7:0]           sseg,
    output logic                 frame_done
);

    localparam int c_cnt_w  = $clog2(SCAN_TICKS);
    localparam int c_idx_w  = $clog2(N_REQ);
    localparam int c_hold_w = $clog2(HOLD_FRAMES) + 1;

    localparam logic [c_cnt_w-1:0]  c_tick_last = c_cnt_w'(SCAN_TICKS - 1);
    localparam logic [c_hold_w-1:0] c_hold_max  = c_hold_w'(HOLD_FRAMES - 1);
    localparam logic [c_idx_w-1:0]  c_idx_last  = c_idx_w'(N_REQ - 1);

    logic [c_cnt_w-1:0]  r_scan_cnt;
    logic [1:0]          r_digit;
    logic [c_idx_w-1:0]  r_rr_ptr;
    logic [c_hold_w-1:0] r_hold_cnt;
    logic [31:0]         r_shadow;

    logic                w_tick;
    logic                w_boundary;
    logic [1:0]          w_digit_nxt;
    logic                w_owned;
    logic [c_idx_w-1:0]  w_owner;
    logic                w_other_req;
    logic                w_keep;
    logic [c_idx_w-1:0]  w_start;
    logic [c_idx_w-1:0]  w_probe;
    logic                w_hit;
    logic [c_idx_w-1:0]  w_hit_idx;
    logic [N_REQ-1:0]    w_grant_nxt;
    logic [c_hold_w-1:0] w_hold_nxt;
    logic [c_idx_w-1:0]  w_rr_nxt;
    logic [31:0]         w_shadow_nxt;
    logic [31:0]         w_shadow_src;

    function automatic logic [c_idx_w-1:0] inc_idx(input logic [c_idx_w-1:0] x);
        return (x == c_idx_last) ? '0 : x + 1'b1;
    endfunction

    assign w_tick      = (r_scan_cnt == c_tick_last);
    assign w_boundary  = w_tick && (r_digit == 2'd3);
    assign w_digit_nxt = r_digit + 2'd1;

    always_comb begin
        w_owned = |grant;
        w_owner = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) w_owner = c_idx_w'(i);
        end
    end

    assign w_other_req = |(req & ~grant);
    // Hold is only honoured while the owner still requests; with no competitor
    // the owner keeps the display indefinitely.
    assign w_keep  = w_owned && req[w_owner] &&
                     ((r_hold_cnt < c_hold_max) || !w_other_req);
    assign w_start = w_owned ? inc_idx(w_owner) : r_rr_ptr;

    // Starting one past the owner puts the owner last in the search order.
    always_comb begin
        w_hit     = 1'b0;
        w_hit_idx = '0;
        w_probe   = w_start;
        for (int k = 0; k < N_REQ; k++) begin
            if (!w_hit && req[w_probe]) begin
                w_hit     = 1'b1;
                w_hit_idx = w_probe;
            end
            w_probe = inc_idx(w_probe);
        end
    end

    always_comb begin
        w_grant_nxt  = '0;
        w_hold_nxt   = '0;
        w_rr_nxt     = r_rr_ptr;
        w_shadow_nxt = 32'hFFFF_FFFF;
        if (w_keep) begin
            w_grant_nxt  = grant;
            w_hold_nxt   = (r_hold_cnt < c_hold_max) ? r_hold_cnt + 1'b1 : r_hold_cnt;
            w_shadow_nxt = frame[32*int'(w_owner) +: 32];
        end else if (w_hit) begin
            w_grant_nxt[w_hit_idx] = 1'b1;
            w_rr_nxt               = inc_idx(w_hit_idx);
            w_shadow_nxt           = frame[32*int'(w_hit_idx) +: 32];
        end
    end

    // Idle shadow is all-ones, so blanking needs no separate owner test.
    assign w_shadow_src = w_boundary ? w_shadow_nxt : r_shadow;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_scan_cnt <= '0;
            r_digit    <= 2'd3;
            an         <= 4'b1111;
            sseg       <= 8'hFF;
            grant      <= '0;
            frame_done <= 1'b0;
            r_rr_ptr   <= '0;
            r_hold_cnt <= '0;
            r_shadow   <= 32'hFFFF_FFFF;
        end else begin
            frame_done <= w_boundary;
            if (w_tick) begin
                r_scan_cnt <= '0;
                r_digit    <= w_digit_nxt;
                an         <= ~(4'b0001 << w_digit_nxt);
                sseg       <= w_shadow_src[{w_digit_nxt, 3'b000} +: 8];
            end else begin
                r_scan_cnt <= r_scan_cnt + 1'b1;
            end
            if (w_boundary) begin
                grant      <= w_grant_nxt;
                r_hold_cnt <= w_hold_nxt;
                r_rr_ptr   <= w_rr_nxt;
                r_shadow   <= w_shadow_nxt;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sseg_display_arbiter.sv
//==============================================================================
// Module  : tb_sseg_display_arbiter
// Brief   : Directed self-checking bench for sseg_display_arbiter.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_sseg_display_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [1:0]  req = 2'b00;
    logic [63:0] frame = '1;
    logic [1:0]  grant;
    logic [3:0]  an;
    logic [7:0]  sseg;
    logic        frame_done;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    localparam logic [31:0] c_f0 = 32'hB0A4F9C0;
    localparam logic [31:0] c_f1 = 32'h92998882;

    sseg_display_arbiter #(
        .N_REQ      (2),
        .SCAN_TICKS (4),
        .HOLD_FRAMES(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .frame     (frame),
        .grant     (grant),
        .an        (an),
        .sseg      (sseg),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic adv_to(input int target);
        while (cyc < target) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    // Release lands on a negedge; cyc counts negedges since release.
    task automatic do_reset(input logic [1:0] r, input logic [31:0] f0, input logic [31:0] f1);
        rst   = 1'b1;
        req   = r;
        frame = {f1, f0};
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        // T1: idle scanning
        do_reset(2'b00, c_f0, c_f1);
        chk("t1_rst_an", 32'(an), 32'hF);
        chk("t1_rst_sseg", 32'(sseg), 32'hFF);
        chk("t1_rst_grant", 32'(grant), 32'h0);
        chk("t1_rst_fd", 32'(frame_done), 32'h0);
        for (int c = 1; c <= 19; c++) begin
            adv_to(c);
            if (c < 4) begin
                chk($sformatf("t1_pre_an_c%0d", c), 32'(an), 32'hF);
            end else begin
                chk($sformatf("t1_an_c%0d", c), 32'(an), 32'(~(4'b0001 << ((c - 4) / 4)) & 4'hF));
                chk($sformatf("t1_fd_c%0d", c), 32'(frame_done), 32'((c % 16) == 4));
            end
            chk($sformatf("t1_sseg_c%0d", c), 32'(sseg), 32'hFF);
            chk($sformatf("t1_grant_c%0d", c), 32'(grant), 32'h0);
        end

        // T2: single owner shows its frame digit by digit
        do_reset(2'b01, c_f0, c_f1);
        adv_to(3);
        chk("t2_pre_grant", 32'(grant), 32'h0);
        adv_to(4);
        chk("t2_grant", 32'(grant), 32'h1);
        chk("t2_an0", 32'(an), 32'hE);
        chk("t2_d0", 32'(sseg), 32'hC0);
        adv_to(8);
        chk("t2_d1", 32'(sseg), 32'hF9);
        chk("t2_an1", 32'(an), 32'hD);
        adv_to(12);
        chk("t2_d2", 32'(sseg), 32'hA4);
        adv_to(16);
        chk("t2_d3", 32'(sseg), 32'hB0);
        chk("t2_an3", 32'(an), 32'h7);

        // T3: both requesting, hold of two frames
        do_reset(2'b11, c_f0, c_f1);
        for (int k = 0; k < 5; k++) begin
            logic [1:0] g_exp;
            g_exp = (k == 2 || k == 3) ? 2'b10 : 2'b01;
            adv_to(4 + 16 * k);
            chk($sformatf("t3_grant_b%0d", k), 32'(grant), 32'(g_exp));
            chk($sformatf("t3_sseg_b%0d", k), 32'(sseg), (g_exp == 2'b01) ? 32'hC0 : 32'h82);
            chk($sformatf("t3_fd_b%0d", k), 32'(frame_done), 32'h1);
        end

        // T4: mid-frame frame change is deferred to the next frame
        do_reset(2'b01, c_f0, c_f1);
        adv_to(9);
        frame[23:16] = 8'h99;
        adv_to(12);
        chk("t4_old_d2", 32'(sseg), 32'hA4);
        adv_to(28);
        chk("t4_new_d2", 32'(sseg), 32'h99);
        chk("t4_grant", 32'(grant), 32'h1);

        // T5: owner releases mid-frame, other requester takes over at boundary
        do_reset(2'b01, c_f0, c_f1);
        adv_to(6);
        req = 2'b10;
        adv_to(8);
        chk("t5_hold_g_c8", 32'(grant), 32'h1);
        chk("t5_hold_s_c8", 32'(sseg), 32'hF9);
        adv_to(19);
        chk("t5_hold_g_c19", 32'(grant), 32'h1);
        adv_to(20);
        chk("t5_new_grant", 32'(grant), 32'h2);
        chk("t5_new_sseg", 32'(sseg), 32'h82);
        adv_to(24);
        chk("t5_new_d1", 32'(sseg), 32'h88);

        // T6: asynchronous reset between edges
        do_reset(2'b01, c_f0, c_f1);
        adv_to(10);
        chk("t6_pre_grant", 32'(grant), 32'h1);
        rst = 1'b1;
        #1;
        chk("t6_async_an", 32'(an), 32'hF);
        chk("t6_async_sseg", 32'(sseg), 32'hFF);
        chk("t6_async_grant", 32'(grant), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        cyc = 0;
        adv_to(3);
        chk("t6_restart_an", 32'(an), 32'hF);
        adv_to(4);
        chk("t6_restart_an0", 32'(an), 32'hE);
        chk("t6_restart_sseg", 32'(sseg), 32'hC0);
        chk("t6_restart_fd", 32'(frame_done), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
